// File: rtl/decode_scoreboard.sv
// decode_scoreboard
//   Single-entry decode stage placed ahead of the register file. It holds one
//   16-bit instruction, decodes it into register addresses and an immediate,
//   and issues it to execute only when no register it reads or writes is still
//   waiting on writeback. A per-register busy scoreboard tracks the writes that
//   are outstanding.
//
// Ports
//   clock, reset          rising-edge clock, synchronous active-high reset
//   in_valid/in_ready     instruction handshake, in_instr = {op, rd, rs1, rs2/imm}
//   out_valid/out_ready   issue handshake toward execute
//   out_op, out_rd        opcode and destination of the held instruction
//   out_wen               op writes out_rd (never set for r0)
//   out_imm               decoded, sign-extended immediate
//   rf_rs1, rf_rs2        register file read addresses, 0 when operand unused
//   wb_valid, wb_rd       writeback completion, clears busy[wb_rd]
//   flush                 drop the held, not-yet-issued instruction
//   halted                HALT has issued; only reset leaves this state
//
// state   | meaning
// --------+-------------------------------------------------------------
// RUN     | accepting, decoding and issuing instructions
// HALTED  | HALT issued; no accept, no issue, writebacks still retire

module decode_scoreboard #(
  parameter int NUM_REG = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [15:0] in_instr,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_op,
  output logic [3:0]  out_rd,
  output logic        out_wen,
  output logic [15:0] out_imm,
  output logic [3:0]  rf_rs1,
  output logic [3:0]  rf_rs2,
  input  logic        wb_valid,
  input  logic [3:0]  wb_rd,
  input  logic        flush,
  output logic        halted
);

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic                 held_valid_q, held_valid_d;
  logic [15:0]          held_instr_q, held_instr_d;
  logic [NUM_REG-1:0]   busy_q, busy_d;

  function automatic logic [NUM_REG-1:0] reg_sel(input logic [3:0] addr);
    reg_sel = '0;
    for (int i = 0; i < NUM_REG; i++) begin
      if (addr == i[3:0]) reg_sel[i] = 1'b1;
    end
  endfunction

  logic [3:0]         f_op, f_rd, f_rs1, f_rs2;
  logic               use_rs1, use_rs2, op_writes, is_halt;
  logic [NUM_REG-1:0] wb_clr, busy_eff, set_vec;
  logic               hazard, issue, accept;

  assign f_op  = held_instr_q[15:12];
  assign f_rd  = held_instr_q[11:8];
  assign f_rs1 = held_instr_q[7:4];
  assign f_rs2 = held_instr_q[3:0];

  always_comb begin
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    op_writes = 1'b0;
    is_halt   = 1'b0;
    out_imm   = 16'h0000;
    unique case (f_op)
      4'h0: ;
      4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
        use_rs1   = 1'b1;
        use_rs2   = 1'b1;
        op_writes = 1'b1;
      end
      4'h8, 4'hA: begin
        use_rs1   = 1'b1;
        op_writes = 1'b1;
        out_imm   = {{12{held_instr_q[3]}}, held_instr_q[3:0]};
      end
      4'h9: begin
        op_writes = 1'b1;
        out_imm   = {held_instr_q[7:0], 8'h00};
      end
      4'hB, 4'hC, 4'hD: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        out_imm = {{12{held_instr_q[11]}}, held_instr_q[11:8]};
      end
      4'hE: begin
        op_writes = 1'b1;
        out_imm   = {{8{held_instr_q[7]}}, held_instr_q[7:0]};
      end
      4'hF: is_halt = 1'b1;
      default: ;
    endcase
  end

  assign out_op  = f_op;
  assign out_rd  = f_rd;
  assign out_wen = op_writes && (f_rd != 4'd0);
  assign rf_rs1  = use_rs1 ? f_rs1 : 4'd0;
  assign rf_rs2  = use_rs2 ? f_rs2 : 4'd0;

  // A register retiring this cycle is treated as already free, so a stalled
  // consumer issues in the very cycle its producer writes back.
  assign wb_clr   = wb_valid ? reg_sel(wb_rd) : '0;
  assign busy_eff = busy_q & ~wb_clr;

  assign hazard = (use_rs1 && |(busy_eff & reg_sel(f_rs1))) ||
                  (use_rs2 && |(busy_eff & reg_sel(f_rs2))) ||
                  (out_wen && |(busy_eff & reg_sel(f_rd)));

  // HALT waits for the registered scoreboard to drain completely.
  assign out_valid = held_valid_q && !hazard && (state_q == RUN) && !flush &&
                     !reset && (!is_halt || (busy_q == '0));
  assign issue     = out_valid && out_ready;

  // A flush frees the holding register, so a coincident instruction is taken.
  assign in_ready = (state_q == RUN) && !reset &&
                    (!held_valid_q || issue || flush);
  assign accept   = in_valid && in_ready;

  assign halted = (state_q == HALTED);

  assign set_vec = (issue && out_wen) ? reg_sel(f_rd) : '0;

  always_comb begin
    state_d      = state_q;
    held_valid_d = held_valid_q;
    held_instr_d = held_instr_q;
    // Set is applied after clear so a same-cycle set/clear leaves the bit set.
    busy_d       = (busy_q & ~wb_clr) | set_vec;
    busy_d[0]    = 1'b0;

    if (accept) begin
      held_valid_d = 1'b1;
      held_instr_d = in_instr;
    end else if (issue || flush) begin
      held_valid_d = 1'b0;
    end

    if (state_q == RUN && issue && is_halt) state_d = HALTED;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= RUN;
      held_valid_q <= 1'b0;
      held_instr_q <= 16'h0000;
      busy_q       <= '0;
    end else begin
      state_q      <= state_d;
      held_valid_q <= held_valid_d;
      held_instr_q <= held_instr_d;
      busy_q       <= busy_d;
    end
  end

endmodule

// File: tb/tb_decode_scoreboard.sv
module tb_decode_scoreboard;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [15:0] in_instr;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_op;
  logic [3:0]  out_rd;
  logic        out_wen;
  logic [15:0] out_imm;
  logic [3:0]  rf_rs1;
  logic [3:0]  rf_rs2;
  logic        wb_valid;
  logic [3:0]  wb_rd;
  logic        flush;
  logic        halted;

  int n_cmp  = 0;
  int n_fail = 0;

  decode_scoreboard #(.NUM_REG(16)) dut (
    .clock    (clock),
    .reset    (reset),
    .in_valid (in_valid),
    .in_instr (in_instr),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_op   (out_op),
    .out_rd   (out_rd),
    .out_wen  (out_wen),
    .out_imm  (out_imm),
    .rf_rs1   (rf_rs1),
    .rf_rs2   (rf_rs2),
    .wb_valid (wb_valid),
    .wb_rd    (wb_rd),
    .flush    (flush),
    .halted   (halted)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    in_valid = 1'b0;
    flush    = 1'b0;
    wb_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_instr  = 16'h0000;
    out_ready = 1'b1;
    wb_valid  = 1'b0;
    wb_rd     = 4'd0;
    flush     = 1'b0;
    tick();
    tick();
    // ---- reset state ----
    check("rst_in_ready",  32'(in_ready),  0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_halted",    32'(halted),    0);
    check("rst_busy",      32'(dut.busy_q), 0);
    check("rst_out_wen",   32'(out_wen),   0);
    check("rst_imm",       32'(out_imm),   0);
    reset = 1'b0;
    #1;
    check("post_rst_in_ready",  32'(in_ready),  1);
    check("post_rst_out_valid", 32'(out_valid), 0);

    // ---- independent stream ----
    in_valid = 1'b1; in_instr = 16'h1123;
    #1;
    check("s_first_no_valid", 32'(out_valid), 0);
    tick();
    in_instr = 16'h1456;
    #1;
    check("s1_valid", 32'(out_valid), 1);
    check("s1_rd",    32'(out_rd),    1);
    check("s1_rs1",   32'(rf_rs1),    2);
    check("s1_rs2",   32'(rf_rs2),    3);
    check("s1_wen",   32'(out_wen),   1);
    check("s1_ready", 32'(in_ready),  1);
    tick();
    in_instr = 16'h1789;
    #1;
    check("s2_valid", 32'(out_valid), 1);
    check("s2_rd",    32'(out_rd),    4);
    check("s2_busy",  32'(dut.busy_q), 32'h0002);
    tick();
    in_valid = 1'b0;
    #1;
    check("s3_valid", 32'(out_valid), 1);
    check("s3_rd",    32'(out_rd),    7);
    tick();
    check("s_done_valid", 32'(out_valid), 0);
    check("s_busy_final", 32'(dut.busy_q), 32'h0092);

    // ---- RAW hazard ----
    do_reset();
    in_valid = 1'b1; in_instr = 16'h1123;
    tick();
    in_instr = 16'h1412;
    tick();
    in_valid = 1'b0;
    #1;
    check("raw_stall_valid", 32'(out_valid), 0);
    check("raw_stall_ready", 32'(in_ready),  0);
    check("raw_busy",        32'(dut.busy_q), 32'h0002);
    tick();
    check("raw_stall2_valid", 32'(out_valid), 0);
    wb_valid = 1'b1; wb_rd = 4'd1;
    #1;
    check("raw_wb_valid", 32'(out_valid), 1);
    check("raw_wb_ready", 32'(in_ready),  1);
    tick();
    wb_valid = 1'b0;
    #1;
    check("raw_after_busy",  32'(dut.busy_q), 32'h0010);
    check("raw_after_valid", 32'(out_valid), 0);

    // ---- r0 writes and immediates ----
    do_reset();
    in_valid = 1'b1; in_instr = 16'h8056;
    tick();
    in_valid = 1'b0;
    #1;
    check("addi_valid", 32'(out_valid), 1);
    check("addi_wen",   32'(out_wen),   0);
    check("addi_imm",   32'(out_imm),   32'h0006);
    check("addi_rs1",   32'(rf_rs1),    5);
    check("addi_rs2",   32'(rf_rs2),    0);
    tick();
    check("addi_busy",  32'(dut.busy_q), 0);
    in_valid = 1'b1; in_instr = 16'h9345;
    tick();
    in_valid = 1'b0;
    #1;
    check("lui_imm", 32'(out_imm), 32'h4500);
    check("lui_rs1", 32'(rf_rs1),  0);
    check("lui_rs2", 32'(rf_rs2),  0);
    check("lui_wen", 32'(out_wen), 1);
    check("lui_rd",  32'(out_rd),  3);
    tick();
    check("lui_busy", 32'(dut.busy_q), 32'h0008);
    in_valid = 1'b1; in_instr = 16'hE1F0;
    tick();
    in_valid = 1'b0;
    #1;
    check("jal_imm",   32'(out_imm),   32'hFFF0);
    check("jal_rs1",   32'(rf_rs1),    0);
    check("jal_valid", 32'(out_valid), 1);
    tick();
    check("jal_busy", 32'(dut.busy_q), 32'h000A);

    // ---- same-cycle set/clear ----
    do_reset();
    in_valid = 1'b1; in_instr = 16'h1245;
    tick();
    in_instr = 16'h1223;
    tick();
    in_valid = 1'b0;
    #1;
    check("sc_busy_pre", 32'(dut.busy_q), 32'h0004);
    check("sc_stall",    32'(out_valid), 0);
    wb_valid = 1'b1; wb_rd = 4'd2;
    #1;
    check("sc_issue_valid", 32'(out_valid), 1);
    tick();
    wb_valid = 1'b0;
    #1;
    check("sc_busy_post", 32'(dut.busy_q), 32'h0004);

    // ---- flush ----
    do_reset();
    in_valid = 1'b1; in_instr = 16'h1123;
    tick();
    in_instr = 16'h1412;
    tick();
    in_valid = 1'b0;
    #1;
    check("fl_held_pre", 32'(dut.held_valid_q), 1);
    tick();
    flush = 1'b1; in_valid = 1'b1; in_instr = 16'h1567;
    #1;
    check("fl_out_valid", 32'(out_valid), 0);
    check("fl_in_ready",  32'(in_ready),  1);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    check("fl_busy",      32'(dut.busy_q), 32'h0002);
    check("fl_new_held",  32'(dut.held_valid_q), 1);
    check("fl_new_rd",    32'(out_rd), 5);
    check("fl_new_valid", 32'(out_valid), 1);
    tick();
    check("fl_busy_post", 32'(dut.busy_q), 32'h0022);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    check("fl_empty_held", 32'(dut.held_valid_q), 0);
    check("fl_empty_busy", 32'(dut.busy_q), 32'h0022);

    // ---- HALT ----
    do_reset();
    in_valid = 1'b1; in_instr = 16'h1345;
    tick();
    in_instr = 16'hF000;
    tick();
    in_valid = 1'b0;
    #1;
    check("h_wait_valid",  32'(out_valid), 0);
    check("h_wait_halted", 32'(halted),    0);
    check("h_wait_busy",   32'(dut.busy_q), 32'h0008);
    tick();
    wb_valid = 1'b1; wb_rd = 4'd3;
    #1;
    check("h_wb_cycle_valid", 32'(out_valid), 0);
    tick();
    wb_valid = 1'b0;
    #1;
    check("h_drained_busy",  32'(dut.busy_q), 0);
    check("h_drained_valid", 32'(out_valid), 1);
    check("h_op",            32'(out_op), 32'hF);
    tick();
    check("h_halted",    32'(halted),    1);
    check("h_in_ready",  32'(in_ready),  0);
    check("h_out_valid", 32'(out_valid), 0);
    in_valid = 1'b1; in_instr = 16'h1123;
    tick();
    tick();
    check("h_stay_halted", 32'(halted),   1);
    check("h_stay_ready",  32'(in_ready), 0);
    check("h_no_load",     32'(dut.held_valid_q), 0);
    in_valid = 1'b0;
    do_reset();
    check("h_rst_halted", 32'(halted),   0);
    check("h_rst_ready",  32'(in_ready), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
